// File: rtl/read_xbar_datapath.sv
// Read-path datapath of the AXI interconnect: AR slices, R routing
// and per-slave RLAST/ARLEN beat checking under arbiter control.
module read_xbar_datapath #(
  parameter int M = 2,
  parameter int S = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int SW = (S > 1) ? $clog2(S) : 1,
  localparam int IDW = (NUM_OUTSTANDING_TRANS > 1)
                       ? $clog2(NUM_OUTSTANDING_TRANS) : 1,
  localparam int RIDW = MW + IDW
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            m_arvalid,
  output logic [M-1:0]            m_arready,
  input  logic [M*ADDR_WIDTH-1:0] m_araddr,
  input  logic [M*IDW-1:0]        m_arid,
  input  logic [M*8-1:0]          m_arlen,
  output logic [S-1:0]            s_arvalid,
  input  logic [S-1:0]            s_arready,
  output logic [S*ADDR_WIDTH-1:0] s_araddr,
  output logic [S*RIDW-1:0]       s_arid,
  output logic [S*8-1:0]          s_arlen,
  input  logic [S-1:0]            s_rvalid,
  output logic [S-1:0]            s_rready,
  input  logic [S*DATA_WIDTH-1:0] s_rdata,
  input  logic [S*RIDW-1:0]       s_rid,
  input  logic [S*2-1:0]          s_rresp,
  input  logic [S-1:0]            s_rlast,
  output logic [M-1:0]            m_rvalid,
  input  logic [M-1:0]            m_rready,
  output logic [M*DATA_WIDTH-1:0] m_rdata,
  output logic [M*2-1:0]          m_rresp,
  output logic [M-1:0]            m_rlast,
  output logic [M*IDW-1:0]        m_rid,
  output logic [M-1:0]            AR_request_f,
  output logic [M*ADDR_WIDTH-1:0] AR_addr_f,
  output logic [M*IDW-1:0]        AR_id_f,
  input  logic [M-1:0]            AR_grant_f,
  input  logic [M*SW-1:0]         AR_sel_f,
  output logic [S-1:0]            AR_finish_f,
  output logic [S-1:0]            R_request_f,
  output logic [S*RIDW-1:0]       R_id_f,
  output logic [S-1:0]            R_last_f,
  input  logic [S-1:0]            R_grant_f,
  input  logic [S*MW-1:0]         R_sel_f,
  output logic [S-1:0]            rlast_err
);

  localparam int NT = NUM_OUTSTANDING_TRANS;

  typedef enum logic {CHK_IDLE, CHK_BURST} chk_e;

  logic [S-1:0]            full_q, full_d;
  logic [ADDR_WIDTH-1:0]   addr_q [S];
  logic [ADDR_WIDTH-1:0]   addr_d [S];
  logic [RIDW-1:0]         id_q [S];
  logic [RIDW-1:0]         id_d [S];
  logic [7:0]              len_q [S];
  logic [7:0]              len_d [S];
  logic [7:0]              tab_q [M*NT];
  logic [7:0]              tab_d [M*NT];
  logic [M-1:0]            taken_q, taken_d;
  chk_e                    st_q [S];
  chk_e                    st_d [S];
  logic [7:0]              cnt_q [S];
  logic [7:0]              cnt_d [S];
  logic [7:0]              cur [S];
  logic [S-1:0]            err_q, err_d;
  logic [S-1:0]            r_hs;
  int                      ar_sel [M];
  int                      win [M];
  logic [M-1:0]            win_vld;

  function automatic logic [7:0] tab_len(
    input logic [RIDW-1:0] rid
  );
    int k;
    k = int'(rid[RIDW-1:IDW]) * NT + int'(rid[IDW-1:0]);
    tab_len = (k < M*NT) ? tab_q[k] : 8'd0;
  endfunction

  assign AR_request_f = m_arvalid;
  assign AR_addr_f    = m_araddr;
  assign AR_id_f      = m_arid;
  assign s_arvalid    = full_q;
  assign AR_finish_f  = full_q & s_arready;
  assign R_request_f  = s_rvalid;
  assign R_id_f       = s_rid;
  assign r_hs         = s_rvalid & s_rready;
  assign R_last_f     = r_hs & s_rlast;
  assign rlast_err    = err_q;

  always_comb begin
    for (int m = 0; m < M; m++)
      ar_sel[m] = int'(AR_sel_f[m*SW +: SW]);
  end

  // A grant is good for one request: taken blocks re-accept until it drops
  always_comb begin
    m_arready = '0;
    for (int m = 0; m < M; m++)
      if (ar_sel[m] < S)
        m_arready[m] = AR_grant_f[m] & m_arvalid[m]
                     & ~full_q[ar_sel[m]] & ~taken_q[m];
  end

  always_comb begin
    full_d  = full_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    tab_d   = tab_q;
    taken_d = taken_q;
    for (int s = 0; s < S; s++)
      if (full_q[s] && s_arready[s])
        full_d[s] = 1'b0;
    for (int m = M-1; m >= 0; m--) begin
      if (m_arready[m]) begin
        full_d[ar_sel[m]] = 1'b1;
        addr_d[ar_sel[m]] = m_araddr[m*ADDR_WIDTH +: ADDR_WIDTH];
        id_d[ar_sel[m]]   = {MW'(m), m_arid[m*IDW +: IDW]};
        len_d[ar_sel[m]]  = m_arlen[m*8 +: 8];
        if (m*NT + int'(m_arid[m*IDW +: IDW]) < M*NT)
          tab_d[m*NT + int'(m_arid[m*IDW +: IDW])] = m_arlen[m*8 +: 8];
      end
    end
    for (int m = 0; m < M; m++)
      taken_d[m] = AR_grant_f[m] & (taken_q[m] | m_arready[m]);
  end

  always_comb begin
    s_araddr = '0;
    s_arid   = '0;
    s_arlen  = '0;
    for (int s = 0; s < S; s++) begin
      s_araddr[s*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[s];
      s_arid[s*RIDW +: RIDW]               = id_q[s];
      s_arlen[s*8 +: 8]                    = len_q[s];
    end
  end

  // Lowest-indexed granted slave wins each master
  always_comb begin
    for (int m = 0; m < M; m++) begin
      win_vld[m] = 1'b0;
      win[m]     = 0;
      for (int s = S-1; s >= 0; s--)
        if (R_grant_f[s] && int'(R_sel_f[s*MW +: MW]) == m) begin
          win_vld[m] = 1'b1;
          win[m]     = s;
        end
    end
  end

  always_comb begin
    s_rready = '0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = '0;
    m_rid    = '0;
    for (int m = 0; m < M; m++) begin
      if (win_vld[m]) begin
        s_rready[win[m]] = m_rready[m];
        m_rvalid[m]      = s_rvalid[win[m]];
        m_rlast[m]       = s_rlast[win[m]];
        m_rdata[m*DATA_WIDTH +: DATA_WIDTH] =
          s_rdata[win[m]*DATA_WIDTH +: DATA_WIDTH];
        m_rresp[m*2 +: 2] = s_rresp[win[m]*2 +: 2];
        m_rid[m*IDW +: IDW] = s_rid[win[m]*RIDW +: IDW];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < S; s++)
      cur[s] = (st_q[s] == CHK_IDLE)
             ? tab_len(s_rid[s*RIDW +: RIDW]) : cnt_q[s];
  end

  // cur is the number of beats left after the one now on the bus
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int s = 0; s < S; s++) begin
      if (r_hs[s]) begin
        if (s_rlast[s] != (cur[s] == 8'd0))
          err_d[s] = 1'b1;
        if (s_rlast[s]) begin
          st_d[s]  = CHK_IDLE;
          cnt_d[s] = 8'd0;
        end else begin
          st_d[s]  = CHK_BURST;
          cnt_d[s] = (cur[s] == 8'd0) ? 8'd0 : cur[s] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      full_q  <= '0;
      taken_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < S; s++) begin
        addr_q[s] <= '0;
        id_q[s]   <= '0;
        len_q[s]  <= '0;
        st_q[s]   <= CHK_IDLE;
        cnt_q[s]  <= '0;
      end
      for (int i = 0; i < M*NT; i++)
        tab_q[i] <= '0;
    end else begin
      full_q  <= full_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tab_q   <= tab_d;
    end
  end

endmodule

// File: tb/tb_read_xbar_datapath.sv
// Bench for read_xbar_datapath: scenario tasks plus AR/R
// scoreboards popped on observed handshakes.
module tb_read_xbar_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  m_arvalid, m_arready;
  logic [63:0] m_araddr;
  logic [1:0]  m_arid;
  logic [15:0] m_arlen;
  logic [1:0]  s_arvalid, s_arready;
  logic [63:0] s_araddr;
  logic [3:0]  s_arid;
  logic [15:0] s_arlen;
  logic [1:0]  s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rid;
  logic [3:0]  s_rresp;
  logic [1:0]  s_rlast;
  logic [1:0]  m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [3:0]  m_rresp;
  logic [1:0]  m_rlast;
  logic [1:0]  m_rid;
  logic [1:0]  AR_request_f;
  logic [63:0] AR_addr_f;
  logic [1:0]  AR_id_f;
  logic [1:0]  AR_grant_f, AR_sel_f, AR_finish_f;
  logic [1:0]  R_request_f, R_last_f;
  logic [3:0]  R_id_f;
  logic [1:0]  R_grant_f, R_sel_f;
  logic [1:0]  rlast_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          s;
    logic [31:0] addr;
    logic [1:0]  id;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        id;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];

  read_xbar_datapath #(
    .M(2), .S(2), .NUM_OUTSTANDING_TRANS(2),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .clr(clr),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .AR_request_f(AR_request_f), .AR_addr_f(AR_addr_f),
    .AR_id_f(AR_id_f), .AR_grant_f(AR_grant_f),
    .AR_sel_f(AR_sel_f), .AR_finish_f(AR_finish_f),
    .R_request_f(R_request_f), .R_id_f(R_id_f),
    .R_last_f(R_last_f), .R_grant_f(R_grant_f),
    .R_sel_f(R_sel_f), .rlast_err(rlast_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m_arvalid  = '0; m_araddr = '0; m_arid = '0; m_arlen = '0;
    s_arready  = '0; s_rvalid = '0; s_rdata = '0; s_rid = '0;
    s_rresp    = '0; s_rlast = '0; m_rready = '0;
    AR_grant_f = '0; AR_sel_f = '0;
    R_grant_f  = '0; R_sel_f = '0;
  endtask

  // AR scoreboard: push on master handshake, pop on slave handshake
  always @(negedge clk) begin
    if (!clr) begin
      ar_q.delete();
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (s_arvalid[s] && s_arready[s]) begin
          n_checks++;
          if (ar_q.size() == 0) begin
            n_errors++;
            $display("FAIL ar_sb: unexpected AR on slave %0d", s);
          end else begin
            ar_t e;
            e = ar_q.pop_front();
            if (e.s != s || s_araddr[s*32 +: 32] !== e.addr ||
                s_arid[s*2 +: 2] !== e.id ||
                s_arlen[s*8 +: 8] !== e.len) begin
              n_errors++;
              $display("FAIL ar_sb: got s%0d %h %b %0d exp s%0d %h %b %0d",
                       s, s_araddr[s*32 +: 32], s_arid[s*2 +: 2],
                       s_arlen[s*8 +: 8], e.s, e.addr, e.id, e.len);
            end
          end
        end
      end
      for (int m = 0; m < 2; m++)
        if (m_arvalid[m] && m_arready[m])
          ar_q.push_back('{int'(AR_sel_f[m]), m_araddr[m*32 +: 32],
                           {1'(m), m_arid[m]}, m_arlen[m*8 +: 8]});
    end
  end

  // R scoreboard: expected beats pushed by the driving task
  always @(negedge clk) begin
    if (clr) begin
      for (int m = 0; m < 2; m++) begin
        if (m_rvalid[m] && m_rready[m]) begin
          n_checks++;
          if (r_q.size() == 0) begin
            n_errors++;
            $display("FAIL r_sb: unexpected beat on master %0d", m);
          end else begin
            r_t e;
            e = r_q.pop_front();
            if (e.m != m || m_rdata[m*32 +: 32] !== e.data ||
                m_rid[m] !== e.id || m_rresp[m*2 +: 2] !== e.resp ||
                m_rlast[m] !== e.last) begin
              n_errors++;
              $display("FAIL r_sb: got m%0d %h %b %b %b exp m%0d %h %b %b %b",
                       m, m_rdata[m*32 +: 32], m_rid[m],
                       m_rresp[m*2 +: 2], m_rlast[m],
                       e.m, e.data, e.id, e.resp, e.last);
            end
          end
        end
      end
    end
  end

  task automatic issue_ar(input int m, input int s, input logic id,
                          input logic [7:0] len,
                          input logic [31:0] addr);
    m_arvalid[m] = 1'b1;
    m_araddr[m*32 +: 32] = addr;
    m_arid[m] = id;
    m_arlen[m*8 +: 8] = len;
    AR_grant_f[m] = 1'b1;
    AR_sel_f[m] = 1'(s);
    s_arready[s] = 1'b1;
    tick;
    m_arvalid = '0;
    AR_grant_f = '0;
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    idle_inputs;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({m_arready, s_arvalid, AR_finish_f, s_rready,
         m_rvalid, rlast_err} !== 12'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: got %b exp 0",
               {m_arready, s_arvalid, AR_finish_f, s_rready,
                m_rvalid, rlast_err});
    end
    n_checks++;
    if ({s_araddr, s_arid, s_arlen} !== 84'b0) begin
      n_errors++;
      $display("FAIL reset_ar: got %h exp 0",
               {s_araddr, s_arid, s_arlen});
    end
    n_checks++;
    if ({m_rdata, m_rresp, m_rlast, m_rid} !== 72'b0) begin
      n_errors++;
      $display("FAIL reset_r: got %h exp 0",
               {m_rdata, m_rresp, m_rlast, m_rid});
    end
    #1 clr = 1'b1;
  endtask

  task automatic test_ar_path;
    tick;
    m_arvalid = 2'b01;
    m_araddr[31:0] = 32'h1000_0040;
    m_arid[0] = 1'b1;
    m_arlen[7:0] = 8'd3;
    AR_grant_f = 2'b01;
    AR_sel_f[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_arready !== 2'b01) begin
      n_errors++;
      $display("FAIL ar_ready: got %b exp 01", m_arready);
    end
    n_checks++;
    if (AR_request_f !== 2'b01 || AR_addr_f[31:0] !== 32'h1000_0040 ||
        AR_id_f[0] !== 1'b1 || AR_finish_f !== 2'b00) begin
      n_errors++;
      $display("FAIL ar_arb_if: got %b %h %b %b exp 01 10000040 1 00",
               AR_request_f, AR_addr_f[31:0], AR_id_f[0], AR_finish_f);
    end
    tick;
    @(negedge clk);
    n_checks++;
    if (s_arvalid !== 2'b10 || m_arready !== 2'b00) begin
      n_errors++;
      $display("FAIL ar_slice: got arvalid %b arready %b exp 10 00",
               s_arvalid, m_arready);
    end
    n_checks++;
    if ({s_araddr[63:32], s_arid[3:2], s_arlen[15:8]} !==
        {32'h1000_0040, 2'b01, 8'd3}) begin
      n_errors++;
      $display("FAIL ar_payload: got %h %b %0d exp 10000040 01 3",
               s_araddr[63:32], s_arid[3:2], s_arlen[15:8]);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      n_checks++;
      if (s_arvalid !== 2'b10 || s_araddr[63:32] !== 32'h1000_0040 ||
          s_arid[3:2] !== 2'b01 || s_arlen[15:8] !== 8'd3 ||
          m_arready !== 2'b00 || AR_finish_f !== 2'b00) begin
        n_errors++;
        $display("FAIL ar_hold%0d: got %b %h %b %0d %b %b", i,
                 s_arvalid, s_araddr[63:32], s_arid[3:2],
                 s_arlen[15:8], m_arready, AR_finish_f);
      end
    end
    tick;
    s_arready = 2'b10;
    @(negedge clk);
    n_checks++;
    if (AR_finish_f !== 2'b10) begin
      n_errors++;
      $display("FAIL ar_finish: got %b exp 10", AR_finish_f);
    end
    tick;
    s_arready = 2'b00;
    @(negedge clk);
    n_checks++;
    if (s_arvalid !== 2'b00 || AR_finish_f !== 2'b00 ||
        m_arready !== 2'b00) begin
      n_errors++;
      $display("FAIL ar_taken: got %b %b %b exp 00 00 00",
               s_arvalid, AR_finish_f, m_arready);
    end
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_r_burst;
    tick;
    issue_ar(1, 0, 1'b1, 8'd3, 32'h2000_0000);
    R_grant_f = 2'b01;
    R_sel_f[0] = 1'b1;
    m_rready = 2'b10;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        m_rready = 2'b00;
        s_rvalid[0] = 1'b1;
        s_rlast[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_rready !== 2'b00 || m_rvalid !== 2'b10) begin
          n_errors++;
          $display("FAIL r_stall: got rready %b rvalid %b exp 00 10",
                   s_rready, m_rvalid);
        end
        tick;
        m_rready = 2'b10;
      end
      s_rvalid[0] = 1'b1;
      s_rdata[31:0] = 32'hA000_0000 + b;
      s_rid[1:0] = 2'b11;
      s_rresp[1:0] = 2'(b);
      s_rlast[0] = (b == 3);
      r_q.push_back('{1, 32'hA000_0000 + b, 1'b1, 2'(b), b == 3});
      @(negedge clk);
      n_checks++;
      if (s_rready !== 2'b01 || m_rvalid !== 2'b10 ||
          m_rid[1] !== 1'b1) begin
        n_errors++;
        $display("FAIL r_route%0d: got %b %b %b exp 01 10 1", b,
                 s_rready, m_rvalid, m_rid[1]);
      end
      n_checks++;
      if (R_last_f !== ((b == 3) ? 2'b01 : 2'b00) ||
          R_request_f !== 2'b01 || R_id_f[1:0] !== 2'b11) begin
        n_errors++;
        $display("FAIL r_arb_if%0d: got %b %b %b", b,
                 R_last_f, R_request_f, R_id_f[1:0]);
      end
      if (b == 0) begin
        n_checks++;
        if (m_rvalid[0] !== 1'b0 || m_rdata[31:0] !== 32'h0) begin
          n_errors++;
          $display("FAIL r_nowin: got %b %h exp 0 0",
                   m_rvalid[0], m_rdata[31:0]);
        end
      end
      tick;
    end
    idle_inputs;
    @(negedge clk);
    n_checks++;
    if (rlast_err !== 2'b00) begin
      n_errors++;
      $display("FAIL r_burst_err: got %b exp 00", rlast_err);
    end
    tick;
  endtask

  task automatic test_r_priority;
    tick;
    issue_ar(0, 0, 1'b0, 8'd0, 32'h3000_0000);
    R_grant_f = 2'b11;
    R_sel_f = 2'b00;
    m_rready = 2'b01;
    s_rvalid = 2'b11;
    s_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
    s_rid = 4'b0000;
    s_rlast = 2'b11;
    r_q.push_back('{0, 32'hAAAA_0000, 1'b0, 2'b00, 1'b1});
    @(negedge clk);
    n_checks++;
    if (s_rready !== 2'b01 || m_rdata[31:0] !== 32'hAAAA_0000) begin
      n_errors++;
      $display("FAIL r_prio: got %b %h exp 01 aaaa0000",
               s_rready, m_rdata[31:0]);
    end
    tick;
    R_grant_f = 2'b10;
    s_rvalid = 2'b10;
    r_q.push_back('{0, 32'hBBBB_0001, 1'b0, 2'b00, 1'b1});
    @(negedge clk);
    n_checks++;
    if (s_rready !== 2'b10 || m_rvalid !== 2'b01 ||
        m_rdata[31:0] !== 32'hBBBB_0001) begin
      n_errors++;
      $display("FAIL r_prio_next: got %b %b %h exp 10 01 bbbb0001",
               s_rready, m_rvalid, m_rdata[31:0]);
    end
    tick;
    idle_inputs;
    @(negedge clk);
    n_checks++;
    if (rlast_err !== 2'b00) begin
      n_errors++;
      $display("FAIL r_prio_err: got %b exp 00", rlast_err);
    end
  endtask

  task automatic test_rlast_err;
    tick;
    R_grant_f = 2'b10;
    R_sel_f[1] = 1'b0;
    m_rready = 2'b01;
    s_rvalid[1] = 1'b1;
    s_rdata[63:32] = 32'hC000_0000;
    s_rid[3:2] = 2'b01;
    s_rlast[1] = 1'b0;
    r_q.push_back('{0, 32'hC000_0000, 1'b1, 2'b00, 1'b0});
    @(negedge clk);
    n_checks++;
    if (rlast_err !== 2'b00) begin
      n_errors++;
      $display("FAIL err_early: got %b exp 00", rlast_err);
    end
    tick;
    s_rdata[63:32] = 32'hC000_0001;
    s_rlast[1] = 1'b1;
    r_q.push_back('{0, 32'hC000_0001, 1'b1, 2'b00, 1'b1});
    @(negedge clk);
    n_checks++;
    if (R_last_f !== 2'b10 || rlast_err !== 2'b00) begin
      n_errors++;
      $display("FAIL err_last: got %b %b exp 10 00", R_last_f, rlast_err);
    end
    tick;
    idle_inputs;
    @(negedge clk);
    n_checks++;
    if (rlast_err !== 2'b10) begin
      n_errors++;
      $display("FAIL err_set: got %b exp 10", rlast_err);
    end
    repeat (3) tick;
    @(negedge clk);
    n_checks++;
    if (rlast_err !== 2'b10) begin
      n_errors++;
      $display("FAIL err_sticky: got %b exp 10", rlast_err);
    end
  endtask

  task automatic test_clr_midflight;
    tick;
    m_arvalid = 2'b01;
    m_araddr[31:0] = 32'h4000_0000;
    m_arid[0] = 1'b1;
    m_arlen[7:0] = 8'd2;
    AR_grant_f = 2'b01;
    AR_sel_f[0] = 1'b0;
    tick;
    idle_inputs;
    @(negedge clk);
    n_checks++;
    if (s_arvalid !== 2'b01) begin
      n_errors++;
      $display("FAIL clr_pre: got %b exp 01", s_arvalid);
    end
    #1 clr = 1'b0;
    #1;
    n_checks++;
    if (s_arvalid !== 2'b00 || AR_finish_f !== 2'b00 ||
        rlast_err !== 2'b00 || s_araddr !== 64'h0) begin
      n_errors++;
      $display("FAIL clr_async: got %b %b %b %h exp 00 00 00 0",
               s_arvalid, AR_finish_f, rlast_err, s_araddr);
    end
    @(negedge clk);
    #1 clr = 1'b1;
    tick;
    m_arvalid = 2'b10;
    m_araddr[63:32] = 32'h5000_0000;
    m_arid[1] = 1'b1;
    m_arlen[15:8] = 8'd5;
    AR_grant_f = 2'b10;
    AR_sel_f[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_arready !== 2'b10) begin
      n_errors++;
      $display("FAIL clr_ready: got %b exp 10", m_arready);
    end
    tick;
    idle_inputs;
    @(negedge clk);
    n_checks++;
    if (s_arvalid !== 2'b10 || s_arid[3:2] !== 2'b11 ||
        s_arlen[15:8] !== 8'd5 || s_araddr[63:32] !== 32'h5000_0000) begin
      n_errors++;
      $display("FAIL clr_route: got %b %b %0d %h exp 10 11 5 50000000",
               s_arvalid, s_arid[3:2], s_arlen[15:8], s_araddr[63:32]);
    end
    tick;
    s_arready = 2'b10;
    @(negedge clk);
    n_checks++;
    if (AR_finish_f !== 2'b10) begin
      n_errors++;
      $display("FAIL clr_finish: got %b exp 10", AR_finish_f);
    end
    tick;
    idle_inputs;
    tick;
  endtask

  initial begin
    test_reset;
    test_ar_path;
    test_r_burst;
    test_r_priority;
    test_rlast_err;
    test_clr_midflight;
    @(negedge clk);
    n_checks++;
    if (ar_q.size() != 0 || r_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got ar %0d r %0d left exp 0 0",
               ar_q.size(), r_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/read_xbar_datapath.md
# read_xbar_datapath

Read-path datapath of the AXI interconnect, directly downstream of the read arbiter. It moves AR requests from masters to slaves and R beats from slaves to masters, under the arbiter's grant and select outputs. It feeds the arbiter its request, id, finish and last strobes. Each slave has a one-entry AR register slice. Each slave also has an R beat counter that checks RLAST against the ARLEN recorded for the burst.

## Interface
Parameters:
- M, 2, number of masters; MW = $clog2(M)
- S, 2, number of slaves; SW = $clog2(S)
- NUM_OUTSTANDING_TRANS, 2, IDs per master; IDW = $clog2(NUM_OUTSTANDING_TRANS)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, R data width

Ports (per-master and per-slave buses are flattened, index 0 in the LSBs):
- clk  in  1  clock
- clr  in  1  reset; asynchronous, active-low
- m_arvalid / m_arready  in / out  M  master AR handshake
- m_araddr  in  M*ADDR_WIDTH  master AR address
- m_arid  in  M*IDW  master transaction id
- m_arlen  in  M*8  burst length minus 1
- s_arvalid / s_arready  out / in  S  slave AR handshake
- s_araddr  out  S*ADDR_WIDTH  slave AR address
- s_arid  out  S*(MW+IDW)  slave AR id, {master index, txn id}
- s_arlen  out  S*8  slave burst length
- s_rvalid / s_rready  in / out  S  slave R handshake
- s_rdata  in  S*DATA_WIDTH  slave read data
- s_rid  in  S*(MW+IDW)  slave R id
- s_rresp  in  S*2  slave read response
- s_rlast  in  S  slave last beat
- m_rvalid / m_rready  out / in  M  master R handshake
- m_rdata / m_rresp / m_rlast / m_rid  out  M*DATA_WIDTH / M*2 / M / M*IDW  routed R beat; m_rid carries the txn id only
- AR_request_f, AR_addr_f, AR_id_f  out  M, M*ADDR_WIDTH, M*IDW  to arbiter; equal m_arvalid, m_araddr, m_arid
- AR_grant_f, AR_sel_f  in  M, M*SW  from arbiter
- AR_finish_f  out  S  one-cycle pulse on a slave AR handshake
- R_request_f  out  S  equals s_rvalid
- R_id_f  out  S*(MW+IDW)  equals s_rid
- R_last_f  out  S  s_rvalid & s_rready & s_rlast
- R_grant_f, R_sel_f  in  S, S*MW  from arbiter
- rlast_err  out  S  sticky RLAST/ARLEN mismatch flag

## Operation
AR path:
- m_arready[m] = AR_grant[m] & m_arvalid[m] & slice[sel] empty & !taken[m].
- On a master handshake, slice[sel] captures {addr, {m, id}, len}. In the same cycle, len_tab[m][id] <= len and taken[m] <= 1.
- taken[m] clears in the first cycle AR_grant[m] is low. One grant accepts exactly one request.
- A full slice drives s_arvalid=1. On s_arvalid & s_arready the slice empties and AR_finish[s] = 1 for that cycle (combinational).

R path:
- For each master m, the winner is the lowest-indexed slave s with R_grant[s] and R_sel[s]==m.
- The winner's beat is forwarded to m: m_rvalid = s_rvalid, m_rid = s_rid[IDW-1:0], and data/resp/last pass through. s_rready[s] = m_rready[m].
- A granted slave that loses to a lower index gets s_rready=0. Every ungranted slave gets s_rready=0.
- A master with no winner sees m_rvalid=0 and zero data.

Beat checker, one state machine per slave:
- States: IDLE, BURST.
- IDLE -> BURST on the first granted handshake. The counter loads len_tab[s_rid master][s_rid txn].
- In BURST, each handshake decrements the counter.
- rlast_err[s] sets if s_rlast arrives with counter != 0, or if counter == 0 and s_rlast = 0.
- Exit to IDLE on the last-beat handshake. A single-beat burst (len 0) finishes in IDLE.

## Timing
- Reset values: m_arready, s_arvalid, AR_finish, s_rready, m_rvalid, rlast_err = 0; all data outputs 0; slices empty; taken = 0; counters 0; checkers IDLE.
- AR latency: master handshake at cycle t, s_arvalid at t+1, AR_finish in the cycle the slave accepts.
- A full slice holds its contents while s_arready is low.
- The R path is combinational: zero added latency, and backpressure passes straight through.
- Simultaneous capture and drain on the same slice in one cycle is not allowed. Ready requires the slice to be empty at the start of the cycle.
- clr asserted mid-burst drops all in-flight state immediately, with no pulses emitted.

## Test plan
- M0 granted with sel 1, arid 1, arlen 3 -> m_arready[0] pulses once. s_arvalid[1]=1 next cycle with s_arid=2'b01, s_arlen=3. AR_finish[1] pulses on s_arready.
- s_arready[1] held low 5 cycles -> s_arvalid stays 1 with stable payload. m_arready[0] stays 0 with grant still high.
- Slave 0, R_grant=1, R_sel=1, 4 beats with rlast on beat 4 -> m_rvalid[1] 4 beats, m_rid = txn bit. R_last_f[0] pulses on beat 4. rlast_err=0.
- Slaves 0 and 1 both granted to M0 -> only slave 0 gets s_rready. Slave 1 flows once slave 0's grant drops.
- arlen 3 but rlast on beat 2 -> rlast_err[s]=1 and stays 1 until clr.
- clr pulsed with a slice full -> s_arvalid=0 immediately. Next accepted request is routed correctly.
